ball_split_engine: RTL and testbench
====================================

# ball_split_engine

Sequential successor to the single-ball split speed calculator. It manages a pool of `NUM_SLOTS` ball slots. On a split request it frees the hit parent slot and computes the children's speeds. It then writes up to two children, one per cycle, into the ball register file through a write port, and tracks slot occupancy. It sits between the hit-detection logic and the per-slot ball movement registers in the game top.

## Interface
Parameters:
- `NUM_SLOTS`, 8 — number of ball slots; at least 2.
- `SPEED_W`, 11 — signed speed width, two's complement.
- `LVL_W`, 2 — ball size-level width.
- `MAX_LEVEL`, 3 — a ball at this level is destroyed, not split.
- `X_BOOST`, 16 — added to |X| per split (macro only).
- `X_MAX`, 256 — |X| saturation limit (macro only).
- `INIT_MASK`, 1 — `alive_mask` value after reset.

Derived: `IDX_W` = $clog2(`NUM_SLOTS`).

Ports:
- `clk` in 1 — single clock, rising edge.
- `resetN` in 1 — asynchronous, active-low reset.
- `split_req` in 1 — split request; accepted only when `ready`=1.
- `split_idx` in `IDX_W` — parent slot index.
- `split_xspeed` in `SPEED_W` — parent X speed.
- `split_yspeed` in `SPEED_W` — parent Y speed.
- `split_level` in `LVL_W` — parent level.
- `kill_req` in 1 — external slot kill, e.g. ball removed.
- `kill_idx` in `IDX_W` — slot to kill.
- `ready` out 1 — engine idle and able to accept a split.
- `wr_en` out 1 — one-cycle child write strobe.
- `wr_idx` out `IDX_W` — slot being written.
- `wr_xspeed` out `SPEED_W` — child X speed.
- `wr_yspeed` out `SPEED_W` — child Y speed.
- `wr_level` out `LVL_W` — child level.
- `done` out 1 — one-cycle pulse when the split completes.
- `overflow` out 1 — one-cycle pulse when the second child is dropped because no slot is free.
- `alive_mask` out `NUM_SLOTS` — slot occupancy, registered.

## Operation
- FSM states: IDLE, WR1, WR2, KILL.
- **IDLE**, `ready`=1.
  - On `split_req`: latch all `split_*` inputs and clear `alive_mask[split_idx]`.
  - If the latched level equals `MAX_LEVEL`, go to KILL; otherwise go to WR1.
- **KILL**: pulse `done` with no write, then go to IDLE.
- **WR1**: write child 1 into the parent slot.
  - `wr_idx`=parent, `wr_xspeed`=X1, `wr_yspeed`=Yc, `wr_level`=level+1.
  - Set the alive bit for the parent slot.
  - Go to WR2.
- **WR2**: find the lowest-index free slot F, combinationally from `alive_mask`.
  - If F exists: write `wr_idx`=F, `wr_xspeed`=X2, `wr_yspeed`=Yc, `wr_level`=level+1, and set `alive_mask[F]`.
  - If no slot is free: no write, and pulse `overflow`.
  - In both cases pulse `done`, then go to IDLE.
- Speed rules:
  - X1 = X and X2 = −X, where X is the latched parent X speed.
  - Yc = −|Y|; the children always move upward.
  - Negating the most-negative value saturates to the largest positive value (e.g. −(−1024) → +1023 for `SPEED_W`=11).
- Kill handling:
  - `kill_req` clears `alive_mask[kill_idx]` in every state.
  - If a kill and a set target the same slot in the same cycle, the set wins.
  - A kill of the latched parent during WR1/WR2 has no effect on the parent slot: WR1 re-sets it regardless.
- A `split_req` while `ready`=0 is ignored; it is not queued.
- Outputs are registered. `wr_*`, `done` and `overflow` are valid in the cycle of the state that drives them.

## Timing
- Reset values:
  - state = IDLE, `ready`=1.
  - `wr_en`=0, `wr_idx`=0, `wr_xspeed`=0, `wr_yspeed`=0, `wr_level`=0.
  - `done`=0, `overflow`=0, `alive_mask`=`INIT_MASK`.
- Normal split, request accepted at edge 0:
  - Child 1 write at cycle 1.
  - Child 2 write plus `done` at cycle 2.
  - `ready`=1 at cycle 3.
  - Throughput is one split per 3 cycles.
- Destroy path: `done` at cycle 1, `ready` at cycle 2; `wr_en` stays 0.
- Reset mid-operation: FSM aborts immediately and `alive_mask` returns to `INIT_MASK`. No partial write completes after `resetN` falls.

## Configuration
- Macro `SPLIT_SPEED_BOOST_EN`.
- Defined: child |X| = min(|X| + `X_BOOST`, `X_MAX`), with the sign preserved as +/− for child 1/child 2. X=0 yields +`X_BOOST` / −`X_BOOST`.
- Undefined: X1 = X and X2 = −X exactly; `X_BOOST` and `X_MAX` are unused.

## Test plan
- Reset with defaults, hold 5 cycles → `alive_mask`=8'b0000_0001, `ready`=1, no strobes.
- Split slot 0, X=+40, Y=+30, level 0 → cycle 1 write idx 0 (X=+40, Y=−30, lvl 1); cycle 2 write idx 1 (X=−40, Y=−30, lvl 1) with `done`; mask=8'b0000_0011.
- Split slot 2 at level 3 → `done` only at cycle 1, no `wr_en`, bit 2 cleared.
- Mask 8'hFF, split slot 5 → child 1 written to slot 5; WR2 has no write, `overflow`=1 and `done`=1; mask stays 8'hFF.
- Macro on: X=−1024, `X_BOOST`=16, `X_MAX`=256 → children get X=+256 and −256. Macro off: X=−1024 → children get −1024 and +1023, saturated.
- `kill_req` for slot 1 in the same cycle that WR2 selects slot 1 → slot 1 alive. Then `resetN` low during WR1 → mask = `INIT_MASK` and no further writes.

Source files
------------

// File: rtl/ball_split_engine_if.sv
// Split-engine bus: split requests and slot kills from hit detection, child writes
// and slot occupancy back toward the ball register file.
interface ball_split_engine_if #(
    parameter int NUM_SLOTS = 8,
    parameter int SPEED_W   = 11,
    parameter int LVL_W     = 2
);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    logic                 split_req;
    logic [IDX_W-1:0]     split_idx;
    logic [SPEED_W-1:0]   split_xspeed;
    logic [SPEED_W-1:0]   split_yspeed;
    logic [LVL_W-1:0]     split_level;
    logic                 kill_req;
    logic [IDX_W-1:0]     kill_idx;

    logic                 ready;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [SPEED_W-1:0]   wr_xspeed;
    logic [SPEED_W-1:0]   wr_yspeed;
    logic [LVL_W-1:0]     wr_level;
    logic                 done;
    logic                 overflow;
    logic [NUM_SLOTS-1:0] alive_mask;

    modport master (
        output split_req, split_idx, split_xspeed, split_yspeed, split_level,
        output kill_req, kill_idx,
        input  ready, wr_en, wr_idx, wr_xspeed, wr_yspeed, wr_level,
        input  done, overflow, alive_mask
    );

    modport slave (
        input  split_req, split_idx, split_xspeed, split_yspeed, split_level,
        input  kill_req, kill_idx,
        output ready, wr_en, wr_idx, wr_xspeed, wr_yspeed, wr_level,
        output done, overflow, alive_mask
    );
endinterface

// File: rtl/ball_split_engine.sv
// Ball split engine: frees the hit parent, writes up to two children over two cycles
// and tracks slot occupancy. Optional X speed boost under SPLIT_SPEED_BOOST_EN.
module ball_split_engine #(
    parameter int                   NUM_SLOTS = 8,
    parameter int                   SPEED_W   = 11,
    parameter int                   LVL_W     = 2,
    parameter int                   MAX_LEVEL = 3,
    parameter int                   X_BOOST   = 16,
    parameter int                   X_MAX     = 256,
    parameter logic [NUM_SLOTS-1:0] INIT_MASK = {{(NUM_SLOTS-1){1'b0}}, 1'b1}
) (
    input logic               clk,
    input logic               resetN,
    ball_split_engine_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam logic [SPEED_W-1:0] S_MIN = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic [SPEED_W-1:0] S_MAX = {1'b0, {(SPEED_W-1){1'b1}}};

    if (NUM_SLOTS < 2 || X_BOOST < 0 || X_MAX < 0) begin : g_cfg_invalid
        $error("ball_split_engine: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, WR1, WR2, KILL} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [SPEED_W-1:0] x;
        logic [SPEED_W-1:0] y;
        logic [LVL_W-1:0]   lvl;
    } split_t;

    // Negation that clamps the most-negative code to the largest positive one.
    function automatic logic [SPEED_W-1:0] sat_neg(input logic [SPEED_W-1:0] v);
        return (v == S_MIN) ? S_MAX : (~v + 1'b1);
    endfunction

    // -|Y|: negative values already point upward and are kept as-is.
    function automatic logic [SPEED_W-1:0] up_y(input logic [SPEED_W-1:0] v);
        return v[SPEED_W-1] ? v : sat_neg(v);
    endfunction

`ifdef SPLIT_SPEED_BOOST_EN
    localparam int S_MAX_I = 2 ** (SPEED_W - 1) - 1;
    localparam int LIM     = (X_MAX < S_MAX_I) ? X_MAX : S_MAX_I;

    function automatic logic [SPEED_W-1:0] boost_mag(input logic [SPEED_W-1:0] v);
        logic [SPEED_W+1:0] sum;
        sum = {2'b00, (v[SPEED_W-1] ? (~v + 1'b1) : v)} + (SPEED_W+2)'(X_BOOST);
        if (sum > (SPEED_W+2)'(LIM)) sum = (SPEED_W+2)'(LIM);
        return SPEED_W'(sum);
    endfunction

    function automatic logic [SPEED_W-1:0] child_x1(input logic [SPEED_W-1:0] v);
        return boost_mag(v);
    endfunction

    function automatic logic [SPEED_W-1:0] child_x2(input logic [SPEED_W-1:0] v);
        return ~boost_mag(v) + 1'b1;
    endfunction
`else
    function automatic logic [SPEED_W-1:0] child_x1(input logic [SPEED_W-1:0] v);
        return v;
    endfunction

    function automatic logic [SPEED_W-1:0] child_x2(input logic [SPEED_W-1:0] v);
        return sat_neg(v);
    endfunction
`endif

    state_t               state_q, state_d;
    split_t               par_q, par_d;
    logic [NUM_SLOTS-1:0] mask_q, mask_d;
    logic                 ready_q, ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [SPEED_W-1:0]   wr_x_q, wr_x_d;
    logic [SPEED_W-1:0]   wr_y_q, wr_y_d;
    logic [LVL_W-1:0]     wr_lvl_q, wr_lvl_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 kill_blk;
    logic                 f_vld;
    logic [IDX_W-1:0]     f_idx;

    // Occupancy: kill first so a same-cycle set on the same slot wins.
    always_comb begin
        mask_d   = mask_q;
        kill_blk = (state_q == WR1 || state_q == WR2) && (bus.kill_idx == par_q.idx);
        if (bus.kill_req && !kill_blk) mask_d[bus.kill_idx] = 1'b0;
        case (state_q)
            IDLE:    if (bus.split_req) mask_d[bus.split_idx] = 1'b0;
            WR1:     mask_d[par_q.idx] = 1'b1;
            WR2:     if (wr_en_q) mask_d[wr_idx_q] = 1'b1;
            default: ;
        endcase
    end

    // Second-child slot is picked from the occupancy as it stands once WR1 commits.
    always_comb begin
        f_vld = 1'b0;
        f_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!mask_d[i]) begin
                f_vld = 1'b1;
                f_idx = IDX_W'(i);
            end
        end
    end

    // Outputs are computed one cycle ahead so they are valid during the driving state.
    always_comb begin
        state_d  = state_q;
        par_d    = par_q;
        wr_en_d  = 1'b0;
        wr_idx_d = wr_idx_q;
        wr_x_d   = wr_x_q;
        wr_y_d   = wr_y_q;
        wr_lvl_d = wr_lvl_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.split_req) begin
                    par_d = '{bus.split_idx, bus.split_xspeed, bus.split_yspeed, bus.split_level};
                    if (bus.split_level == LVL_W'(MAX_LEVEL)) begin
                        state_d = KILL;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = WR1;
                        wr_en_d  = 1'b1;
                        wr_idx_d = bus.split_idx;
                        wr_x_d   = child_x1(bus.split_xspeed);
                        wr_y_d   = up_y(bus.split_yspeed);
                        wr_lvl_d = bus.split_level + 1'b1;
                    end
                end
            end
            WR1: begin
                state_d = WR2;
                done_d  = 1'b1;
                if (f_vld) begin
                    wr_en_d  = 1'b1;
                    wr_idx_d = f_idx;
                    wr_x_d   = child_x2(par_q.x);
                    wr_y_d   = up_y(par_q.y);
                    wr_lvl_d = par_q.lvl + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            WR2:     state_d = IDLE;
            KILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            par_q    <= '0;
            mask_q   <= INIT_MASK;
            ready_q  <= 1'b1;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            wr_lvl_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            par_q    <= par_d;
            mask_q   <= mask_d;
            ready_q  <= ready_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            wr_lvl_q <= wr_lvl_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_idx     = wr_idx_q;
    assign bus.wr_xspeed  = wr_x_q;
    assign bus.wr_yspeed  = wr_y_q;
    assign bus.wr_level   = wr_lvl_q;
    assign bus.done       = done_q;
    assign bus.overflow   = ovf_q;
    assign bus.alive_mask = mask_q;
endmodule

// File: tb/tb_ball_split_engine.sv
// Directed bench for ball_split_engine: normal split, destroy, overflow, kill/set race,
// speed saturation and reset abort, with hand-computed expectations.
module tb_ball_split_engine;
    logic clk = 1'b0;
    logic resetN;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ball_split_engine_if #(.NUM_SLOTS(8), .SPEED_W(11), .LVL_W(2)) bus ();

    ball_split_engine dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    function automatic logic [10:0] sp(input int v);
        logic [31:0] t;
        t = v;
        return t[10:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int idx, input int x, input int y, input int lvl);
        bus.split_req    = 1'b1;
        bus.split_idx    = 3'(idx);
        bus.split_xspeed = sp(x);
        bus.split_yspeed = sp(y);
        bus.split_level  = 2'(lvl);
    endtask

    task automatic chk_wr(input string tag, input int idx, input int x, input int y, input int lvl);
        chk({tag, ".en"},  32'(bus.wr_en), 32'd1);
        chk({tag, ".idx"}, 32'(bus.wr_idx), 32'(idx));
        chk({tag, ".x"},   32'(bus.wr_xspeed), 32'(sp(x)));
        chk({tag, ".y"},   32'(bus.wr_yspeed), 32'(sp(y)));
        chk({tag, ".lvl"}, 32'(bus.wr_level), 32'(lvl));
    endtask

    initial begin
        bus.split_req = 1'b0; bus.split_idx = '0; bus.split_xspeed = '0;
        bus.split_yspeed = '0; bus.split_level = '0; bus.kill_req = 1'b0; bus.kill_idx = '0;
        resetN = 1'b0;
        repeat (5) step();
        chk("rst.mask",  32'(bus.alive_mask), 32'h01);
        chk("rst.ready", 32'(bus.ready), 32'd1);
        chk("rst.wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst.done",  32'(bus.done), 32'd0);
        chk("rst.ovf",   32'(bus.overflow), 32'd0);
        chk("rst.wdata", {bus.wr_idx, bus.wr_xspeed, bus.wr_yspeed, bus.wr_level}, 32'd0);
        resetN = 1'b1;
        step();

        // Normal split of slot 0
        req(0, 40, 30, 0);
        step(); bus.split_req = 1'b0;
        chk_wr("n.c1", 0, 40, -30, 1);
        chk("n.c1.ready", 32'(bus.ready), 32'd0);
        chk("n.c1.mask",  32'(bus.alive_mask), 32'h00);
        step();
        chk_wr("n.c2", 1, -40, -30, 1);
        chk("n.c2.done", 32'(bus.done), 32'd1);
        chk("n.c2.ovf",  32'(bus.overflow), 32'd0);
        step();
        chk("n.c3.ready", 32'(bus.ready), 32'd1);
        chk("n.c3.wr_en", 32'(bus.wr_en), 32'd0);
        chk("n.c3.mask",  32'(bus.alive_mask), 32'h03);

        // Split slot 1, negative speeds; a request while busy is dropped
        req(1, -5, -7, 1);
        step();
        req(7, 9, 9, 0);
        chk_wr("b.c1", 1, -5, -7, 2);
        step(); bus.split_req = 1'b0;
        chk_wr("b.c2", 2, 5, -7, 2);
        chk("b.c2.ready", 32'(bus.ready), 32'd0);
        step();
        chk("b.c3.wr_en", 32'(bus.wr_en), 32'd0);
        chk("b.c3.mask",  32'(bus.alive_mask), 32'h07);
        step();
        chk("b.c4.wr_en", 32'(bus.wr_en), 32'd0);

        // Destroy path on slot 2
        req(2, 10, 10, 3);
        step(); bus.split_req = 1'b0;
        chk("d.c1.done",  32'(bus.done), 32'd1);
        chk("d.c1.wr_en", 32'(bus.wr_en), 32'd0);
        chk("d.c1.ready", 32'(bus.ready), 32'd0);
        chk("d.c1.mask",  32'(bus.alive_mask), 32'h03);
        step();
        chk("d.c2.ready", 32'(bus.ready), 32'd1);
        chk("d.c2.done",  32'(bus.done), 32'd0);

        // Idle kill of slot 1, then kill slot 1 during the WR2 that writes it
        bus.kill_req = 1'b1; bus.kill_idx = 3'd1;
        step(); bus.kill_req = 1'b0;
        chk("k.idle.mask", 32'(bus.alive_mask), 32'h01);
        req(0, 1, 0, 2);
        step(); bus.split_req = 1'b0;
        chk_wr("k.c1", 0, 1, 0, 3);
        step();
        bus.kill_req = 1'b1; bus.kill_idx = 3'd1;
        chk_wr("k.c2", 1, -1, 0, 3);
        step(); bus.kill_req = 1'b0;
        chk("k.c3.mask", 32'(bus.alive_mask), 32'h03);

        // Most-negative speeds
        req(1, -1024, -1024, 0);
        step(); bus.split_req = 1'b0;
`ifdef SPLIT_SPEED_BOOST_EN
        chk_wr("s.c1", 1, 256, -1024, 1);
        step();
        chk_wr("s.c2", 2, -256, -1024, 1);
`else
        chk_wr("s.c1", 1, -1024, -1024, 1);
        step();
        chk_wr("s.c2", 2, 1023, -1024, 1);
`endif
        step();
        chk("s.c3.mask", 32'(bus.alive_mask), 32'h07);

        // Fill the pool: children land in slots 3..7
        for (int k = 0; k < 5; k++) begin
            req(0, 0, 0, 0);
            step(); bus.split_req = 1'b0;
            step();
            chk("f.idx", 32'(bus.wr_idx), 32'(k + 3));
            step();
        end
        chk("f.mask", 32'(bus.alive_mask), 32'hFF);

        // Full pool: second child overflows
        req(5, 3, 4, 1);
        step(); bus.split_req = 1'b0;
        chk_wr("o.c1", 5, 3, -4, 2);
        chk("o.c1.mask", 32'(bus.alive_mask), 32'hDF);
        step();
        chk("o.c2.wr_en", 32'(bus.wr_en), 32'd0);
        chk("o.c2.ovf",   32'(bus.overflow), 32'd1);
        chk("o.c2.done",  32'(bus.done), 32'd1);
        step();
        chk("o.c3.ovf",  32'(bus.overflow), 32'd0);
        chk("o.c3.mask", 32'(bus.alive_mask), 32'hFF);

        // Reset during WR1 aborts the split
        req(3, 7, 7, 0);
        step(); bus.split_req = 1'b0;
        chk("r.c1.wr_en", 32'(bus.wr_en), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("r.mask",  32'(bus.alive_mask), 32'h01);
        chk("r.wr_en", 32'(bus.wr_en), 32'd0);
        chk("r.ready", 32'(bus.ready), 32'd1);
        step();
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("r.post.wr", {31'd0, bus.wr_en | bus.done}, 32'd0);
        end
        chk("r.post.mask", 32'(bus.alive_mask), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
